// File: rtl/fsm_self_test_seq_pkg.sv
// fsm_self_test_pkg: scenario codes, sequencer states and timing constants for the self-test sequencer
package fsm_self_test_pkg;
  localparam int NUM_SCENARIOS = 9;
  localparam int DWELL_10US = 1000;
  typedef enum logic [7:0] {
    SC_IDLE,
    SC_FG_WAIT_OPTO,
    SC_FG_WAIT_OPEN,
    SC_WAIT_PHASE_FRONT,
    SC_WAIT_PHASE_DELAY,
    SC_TRIGGER_PROLONG,
    SC_DETECTOR_BUSY,
    SC_DETECTOR_WAIT,
    SC_DETECTOR_FINISHED
  } scenario_t;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} seq_state_t;
endpackage

// File: rtl/fsm_self_test_seq_dwell_counter.sv
// dwell_counter: loadable down-counter with enable and zero flag
module dwell_counter #(
  parameter int DWELL_W = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] value,
  output logic               zero
);
  logic [DWELL_W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && !zero) cnt <= cnt - DWELL_W'(1);
  end
endmodule

// File: rtl/fsm_self_test_seq.sv
// fsm_self_test_seq: steps a scenario code through first..last, holding each code for a programmable dwell
module fsm_self_test_seq
  import fsm_self_test_pkg::*;
#(
  parameter int NUM_STATES = NUM_SCENARIOS,
  parameter int STATE_W    = 8,
  parameter int DWELL_W    = 24,
  parameter int PASS_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               mode_loop,
  input  logic [STATE_W-1:0] first_state,
  input  logic [STATE_W-1:0] last_state,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [STATE_W-1:0] scenario_state,
  output logic               step_strobe,
  output logic               busy,
  output logic               done,
  output logic               cfg_error,
  output logic [PASS_W-1:0]  pass_count
);
  seq_state_t state;
  logic [STATE_W-1:0] first_q, last_q;
  logic [DWELL_W-1:0] dwell_q, dwell_in, load_val;
  logic valid, accept, active, below, reload, zero;
  always_comb begin
    dwell_in = dwell_cycles == '0 ? DWELL_W'(1) : dwell_cycles;
    valid = first_state <= last_state && last_state < STATE_W'(NUM_STATES);
    accept = state == IDLE && start && !stop && valid;
    active = (state == RUN || state == PAUSE) && !stop && !hold;
    below = scenario_state < last_q;
    reload = active && zero && (below || mode_loop);
    load_val = (accept ? dwell_in : dwell_q) - DWELL_W'(1);
  end
  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clock (clock),
    .reset (reset),
    .load  (accept || reload),
    .en    (active),
    .value (load_val),
    .zero  (zero)
  );
  // leaving PAUSE processes the release cycle, so dwell stretches by exactly the hold length
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      scenario_state <= STATE_W'(SC_IDLE);
      step_strobe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_error <= 1'b0;
      pass_count <= '0;
      first_q <= '0;
      last_q <= '0;
      dwell_q <= '0;
    end else begin
      step_strobe <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start && !stop) begin
          if (valid) begin
            state <= RUN;
            first_q <= first_state;
            last_q <= last_state;
            dwell_q <= dwell_in;
            scenario_state <= first_state;
            step_strobe <= 1'b1;
            busy <= 1'b1;
            pass_count <= '0;
            cfg_error <= 1'b0;
          end else cfg_error <= 1'b1;
        end
        RUN, PAUSE: if (stop) begin
          state <= IDLE;
          scenario_state <= '0;
          busy <= 1'b0;
        end else if (hold) state <= PAUSE;
        else begin
          state <= RUN;
          if (zero && below) begin
            scenario_state <= scenario_state + STATE_W'(1);
            step_strobe <= 1'b1;
          end else if (zero) begin
            pass_count <= &pass_count ? pass_count : pass_count + PASS_W'(1);
            if (mode_loop) begin
              scenario_state <= first_q;
              step_strobe <= 1'b1;
            end else begin
              state <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          if (stop) scenario_state <= '0;
        end
      endcase
    end
  end
endmodule
